uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 110 +++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with selectable baud divisor, optional parity and error flags.
module uart_rx #(
    parameter int TICK_DIV0 = 1302,
    parameter int TICK_DIV1 = 651,
    parameter int TICK_DIV2 = 326,
    parameter int TICK_DIV3 = 163
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       active
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      state;
    logic        rx_m, rx_s;
    logic [15:0] tick_cnt, div;
    logic        tick, par_en, perr_q;
    logic [1:0]  baud_q, par_q, bsel;
    logic [3:0]  s_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  sh;
    always_comb begin
        bsel   = state == IDLE ? baud_rate : baud_q;
        div    = bsel == 2'd0 ? 16'(TICK_DIV0) : bsel == 2'd1 ? 16'(TICK_DIV1) :
                 bsel == 2'd2 ? 16'(TICK_DIV2) : 16'(TICK_DIV3);
        tick   = tick_cnt >= div - 16'd1;
        par_en = par_q == 2'b01 || par_q == 2'b10;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) {rx_m, rx_s} <= 2'b11;
        else     {rx_m, rx_s} <= {rx, rx_m};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            s_cnt       <= '0;
            bit_cnt     <= '0;
            sh          <= '0;
            baud_q      <= '0;
            par_q       <= '0;
            perr_q      <= 1'b0;
            data_out    <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            active      <= 1'b0;
        end else begin
            tick_cnt <= (state == IDLE && !rx_s) || tick ? 16'd0 : tick_cnt + 16'd1;
            if (rd_en) rx_valid <= 1'b0;
            case (state)
                IDLE: if (!rx_s) begin
                    state  <= START;
                    active <= 1'b1;
                    s_cnt  <= '0;
                    baud_q <= baud_rate;
                    par_q  <= parity_type;
                end
                START: if (tick) begin
                    s_cnt <= s_cnt == 4'd7 ? 4'd0 : s_cnt + 4'd1;
                    if (s_cnt == 4'd7) begin
                        state   <= rx_s ? IDLE : DATA;
                        active  <= !rx_s;
                        bit_cnt <= '0;
                    end
                end
                DATA: if (tick) begin
                    s_cnt <= s_cnt + 4'd1;
                    if (s_cnt == 4'd15) begin
                        sh      <= {rx_s, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= par_en ? PARITY : STOP;
                    end
                end
                PARITY: if (tick) begin
                    s_cnt <= s_cnt + 4'd1;
                    if (s_cnt == 4'd15) begin
                        perr_q <= rx_s != (^sh ^ (par_q == 2'b01));
                        state  <= STOP;
                    end
                end
                STOP: if (tick) begin
                    s_cnt <= s_cnt + 4'd1;
                    // Leave at mid-stop so the next start edge is never missed
                    if (s_cnt == 4'd15) begin
                        state       <= IDLE;
                        active      <= 1'b0;
                        data_out    <= sh;
                        parity_err  <= par_en & perr_q;
                        frame_err   <= !rx_s;
                        rx_valid    <= 1'b1;
                        overrun_err <= overrun_err | (rx_valid & !rd_en);
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end
endmodule
